// File: rtl/otter_intr_ctrl.sv
// ---------------------------------------------------------------------------
// otter_intr_ctrl
//
// Multi-source interrupt controller for the OTTER MCU. It takes the place of
// the single raw INTR pin. Each external request is synchronised and latched
// into PENDING, either by edge or by level. The highest-priority enabled
// request drives the core's INTR. One claimed source is tracked as in service
// until the CPU writes its id back to the CLAIM/EOI register.
//
// Register map (offsets from BASE_ADDR):
//   0x0 PENDING  R/W1C  (a W1C write has no effect on level-mode bits)
//   0x4 ENABLE   RW
//   0x8 MODE     RW     1 = edge, 0 = level
//   0xC CLAIM    R = {valid, 23'b0, id[7:0]}, W = end-of-interrupt id
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   irq_in_i      raw interrupt requests, asynchronous to clk_i
//   iobus_addr_i  CPU IO address
//   iobus_out_i   CPU IO write data
//   iobus_wr_i    CPU IO write strobe (one cycle per store)
//   int_taken_i   one-cycle pulse from the CU_FSM when the trap is entered
//   intr_o        interrupt request to the CU_FSM
//   irq_rd_o      register read data, combinational from iobus_addr_i
//   irq_hit_o     the address falls inside this 16-byte register block
//
// Build option:
//   OTTER_INTC_RROBIN_EN  When defined, priority rotates. A pointer register
//                         picks the first request at or after it, and after
//                         each claim it moves one past the claimed source.
//                         When undefined, priority is fixed and the lowest
//                         index wins.
// ---------------------------------------------------------------------------
module otter_intr_ctrl #(
  parameter int               N_SRC     = 8,
  parameter logic [31:0]      BASE_ADDR = 32'h1100_0100,
  parameter logic [N_SRC-1:0] MODE_RST  = {N_SRC{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_SRC-1:0] irq_in_i,
  input  logic [31:0]      iobus_addr_i,
  input  logic [31:0]      iobus_out_i,
  input  logic             iobus_wr_i,
  input  logic             int_taken_i,
  output logic             intr_o,
  output logic [31:0]      irq_rd_o,
  output logic             irq_hit_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  localparam logic [1:0] OFS_PENDING = 2'd0;
  localparam logic [1:0] OFS_ENABLE  = 2'd1;
  localparam logic [1:0] OFS_MODE    = 2'd2;
  localparam logic [1:0] OFS_CLAIM   = 2'd3;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] syncOne_q, syncTwo_q, prev_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [7:0]       activeId_q, activeId_d;

  logic [N_SRC-1:0] edgeDet;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] wrData;
  logic [N_SRC-1:0] claimMask;
  logic [N_SRC-1:0] clrMask;
  logic             anyReq;
  logic [7:0]       winId;
  logic             wrPending, wrEnable, wrMode, wrClaim;
  logic             claim, eoi;
  logic             unusedBits;

  // Address bits [1:0] and the data bits above the source count are
  // deliberately ignored.
  assign unusedBits = ^{iobus_addr_i[1:0], iobus_out_i};

  // --- Bus decode --------------------------------------------------------
  assign irq_hit_o = (iobus_addr_i[31:4] == BASE_ADDR[31:4]);
  assign wrData    = iobus_out_i[N_SRC-1:0];
  assign wrPending = iobus_wr_i && irq_hit_o && (iobus_addr_i[3:2] == OFS_PENDING);
  assign wrEnable  = iobus_wr_i && irq_hit_o && (iobus_addr_i[3:2] == OFS_ENABLE);
  assign wrMode    = iobus_wr_i && irq_hit_o && (iobus_addr_i[3:2] == OFS_MODE);
  assign wrClaim   = iobus_wr_i && irq_hit_o && (iobus_addr_i[3:2] == OFS_CLAIM);

  // --- Request path ------------------------------------------------------
  // prev_q trails syncTwo_q by one cycle, so an edge lasts exactly one cycle.
  assign edgeDet = syncTwo_q & ~prev_q;
  assign req     = pending_q & enable_q;
  assign anyReq  = |req;

`ifdef OTTER_INTC_RROBIN_EN
  logic [7:0]         ptr_q, ptr_d;
  logic [2*N_SRC-1:0] reqRot;
  logic [7:0]         rotOfs;
  logic [7:0]         rotSum;

  // Rotate req so that bit 0 lines up with the pointer. Then take the
  // lowest set bit and map it back to a source index, wrapping at N_SRC.
  always_comb begin
    reqRot = {req, req} >> ptr_q;
    rotOfs = 8'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (reqRot[i]) rotOfs = 8'(i);
    end
    rotSum = ptr_q + rotOfs;
    winId  = (rotSum >= 8'(N_SRC)) ? (rotSum - 8'(N_SRC)) : rotSum;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (claim) ptr_d = (winId == 8'(N_SRC - 1)) ? 8'd0 : (winId + 8'd1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= 8'd0;
    else          ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan downwards so the lowest-index request is the
  // last assignment and wins.
  always_comb begin
    winId = 8'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) winId = 8'(i);
    end
  end
`endif

  // --- Claim / end-of-interrupt -----------------------------------------
  // A claim that finds no request (request withdrawn) does nothing.
  assign claim = (state_q == IDLE) && int_taken_i && anyReq;
  assign eoi   = (state_q == SERVICE) && wrClaim && (iobus_out_i[7:0] == activeId_q);

  always_comb begin
    claimMask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claimMask[i] = claim && (winId == 8'(i));
    end
  end

  // Edge bits OR the new edge in after the clear, so a set wins over a clear
  // in the same cycle. Level bits simply mirror the synchronised input.
  always_comb begin
    clrMask   = ({N_SRC{wrPending}} & wrData) | claimMask;
    pending_d = (mode_q & ((pending_q & ~clrMask) | edgeDet)) |
                (~mode_q & syncTwo_q);
    enable_d  = wrEnable ? wrData : enable_q;
    mode_d    = wrMode   ? wrData : mode_q;
  end

  // --- Service FSM -------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    activeId_d = activeId_q;
    intr_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        intr_o = anyReq;
        if (claim) begin
          activeId_d = winId;
          state_d    = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      syncOne_q  <= '0;
      syncTwo_q  <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= MODE_RST;
      activeId_q <= 8'd0;
      state_q    <= IDLE;
    end else begin
      syncOne_q  <= irq_in_i;
      syncTwo_q  <= syncOne_q;
      prev_q     <= syncTwo_q;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      activeId_q <= activeId_d;
      state_q    <= state_d;
    end
  end

  // --- Read mux ----------------------------------------------------------
  // While a source is in service, CLAIM reports that source rather than the
  // current winner.
  always_comb begin
    irq_rd_o = 32'd0;
    unique case (iobus_addr_i[3:2])
      OFS_PENDING: irq_rd_o = 32'(pending_q);
      OFS_ENABLE:  irq_rd_o = 32'(enable_q);
      OFS_MODE:    irq_rd_o = 32'(mode_q);
      OFS_CLAIM: begin
        if (state_q == SERVICE) irq_rd_o = {1'b1, 23'd0, activeId_q};
        else                    irq_rd_o = {anyReq, 23'd0, winId};
      end
      default: irq_rd_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_otter_intr_ctrl
//
// Directed testbench for otter_intr_ctrl with the default parameters
// (N_SRC = 8, BASE_ADDR = 32'h1100_0100, all sources edge-mode at reset).
// Each scenario task drives its own stimulus and checks its own results.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point, away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_otter_intr_ctrl;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irqIn;
  logic [31:0] ioAddr;
  logic [31:0] ioOut;
  logic        ioWr;
  logic        intTaken;
  logic        intr;
  logic [31:0] irqRd;
  logic        irqHit;

  int compared   = 0;
  int mismatched = 0;

  otter_intr_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .irq_in_i     (irqIn),
    .iobus_addr_i (ioAddr),
    .iobus_out_i  (ioOut),
    .iobus_wr_i   (ioWr),
    .int_taken_i  (intTaken),
    .intr_o       (intr),
    .irq_rd_o     (irqRd),
    .irq_hit_o    (irqHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] ofs, input logic [31:0] data);
    ioAddr = BASE + ofs;
    ioOut  = data;
    ioWr   = 1'b1;
    tick(1);
    ioWr   = 1'b0;
    ioOut  = 32'd0;
  endtask

  task automatic busRead(input logic [31:0] ofs, output logic [31:0] data);
    ioAddr = BASE + ofs;
    #1;
    data = irqRd;
  endtask

  task automatic takeIrq();
    intTaken = 1'b1;
    tick(1);
    intTaken = 1'b0;
  endtask

  task automatic pulseIrq(input logic [7:0] mask);
    irqIn = irqIn | mask;
    tick(1);
    irqIn = irqIn & ~mask;
  endtask

  // T1a: values seen during and right after power-on reset.
  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    #3;
    compared++;
    if (intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_intr: got %b expected 0", intr);
    end
    #20;
    rst_n = 1'b1;
    tick(1);
    busRead(32'h4, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_enable: got %h expected 00000000", rd);
    end
    busRead(32'h8, rd);
    compared++;
    if (rd !== 32'h0000_00FF) begin
      mismatched++;
      $display("[TB] FAIL reset_mode: got %h expected 000000ff", rd);
    end
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_claim: got %h expected 00000000", rd);
    end
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_pending: got %h expected 00000000", rd);
    end
  endtask

  // T2: a single edge request, checking latency, claim, and EOI.
  task automatic test_edge();
    logic [31:0] rd;
    busWrite(32'h4, 32'h04);
    pulseIrq(8'h04);
    tick(1);
    compared++;
    if (intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL edge_intr_early: got %b expected 0", intr);
    end
    tick(1);
    compared++;
    if (intr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL edge_intr_3cyc: got %b expected 1", intr);
    end
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h8000_0002) begin
      mismatched++;
      $display("[TB] FAIL edge_claim_idle: got %h expected 80000002", rd);
    end
    takeIrq();
    compared++;
    if (intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL edge_intr_service: got %b expected 0", intr);
    end
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL edge_pending_clr: got %h expected 00000000", rd);
    end
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h8000_0002) begin
      mismatched++;
      $display("[TB] FAIL edge_claim_service: got %h expected 80000002", rd);
    end
    busWrite(32'hC, 32'h2);
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL edge_eoi_idle: got %h expected 00000000", rd);
    end
  endtask

  // T3: two simultaneous requests; the lower index is served first.
  task automatic test_priority();
    logic [31:0] rd;
    busWrite(32'h4, 32'hFF);
    pulseIrq(8'h28);
    tick(2);
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h8000_0003) begin
      mismatched++;
      $display("[TB] FAIL prio_claim_first: got %h expected 80000003", rd);
    end
    takeIrq();
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h20) begin
      mismatched++;
      $display("[TB] FAIL prio_pending_left: got %h expected 00000020", rd);
    end
    busWrite(32'hC, 32'h3);
    compared++;
    if (intr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL prio_intr_reassert: got %b expected 1", intr);
    end
    takeIrq();
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h8000_0005) begin
      mismatched++;
      $display("[TB] FAIL prio_claim_second: got %h expected 80000005", rd);
    end
    busWrite(32'hC, 32'h5);
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL prio_pending_empty: got %h expected 00000000", rd);
    end
  endtask

  // T4: a level-mode source held high through claim and EOI.
  task automatic test_level();
    logic [31:0] rd;
    busWrite(32'h8, 32'hFD);
    irqIn = 8'h02;
    tick(3);
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h02) begin
      mismatched++;
      $display("[TB] FAIL level_pending: got %h expected 00000002", rd);
    end
    busWrite(32'h0, 32'h2);
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h02) begin
      mismatched++;
      $display("[TB] FAIL level_w1c_ignored: got %h expected 00000002", rd);
    end
    takeIrq();
    compared++;
    if (intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL level_intr_service: got %b expected 0", intr);
    end
    busWrite(32'hC, 32'h1);
    compared++;
    if (intr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL level_intr_after_eoi: got %b expected 1", intr);
    end
    irqIn = 8'h00;
    tick(3);
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h0 || intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL level_release: got pending %h intr %b expected 00000000 0", rd, intr);
    end
    busWrite(32'h8, 32'hFF);
  endtask

  // T5: a set colliding with W1C, and an EOI with the wrong id.
  task automatic test_collisions();
    logic [31:0] rd;
    pulseIrq(8'h01);
    tick(2);
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h01) begin
      mismatched++;
      $display("[TB] FAIL coll_first_edge: got %h expected 00000001", rd);
    end
    irqIn = 8'h01;
    tick(1);
    irqIn = 8'h00;
    tick(1);
    busWrite(32'h0, 32'h1);
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h01) begin
      mismatched++;
      $display("[TB] FAIL coll_set_wins: got %h expected 00000001", rd);
    end
    busWrite(32'h0, 32'h1);
    busRead(32'h0, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL coll_w1c_clears: got %h expected 00000000", rd);
    end
    pulseIrq(8'h01);
    tick(2);
    takeIrq();
    busWrite(32'hC, 32'h7);
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h8000_0000 || intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL coll_bad_eoi: got claim %h intr %b expected 80000000 0", rd, intr);
    end
    busWrite(32'hC, 32'h0);
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL coll_good_eoi: got %h expected 00000000", rd);
    end
  endtask

  // Clearing ENABLE drops INTR on the edge where the register changes.
  task automatic test_enable_drop();
    pulseIrq(8'h40);
    tick(2);
    compared++;
    if (intr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL endrop_intr_before: got %b expected 1", intr);
    end
    busWrite(32'h4, 32'h00);
    compared++;
    if (intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL endrop_intr_after: got %b expected 0", intr);
    end
    busWrite(32'h0, 32'h40);
    busWrite(32'h4, 32'hFF);
  endtask

  // T6: address decode and register width.
  task automatic test_decode();
    logic [31:0] rd;
    busWrite(32'h4, 32'h0F);
    ioAddr = BASE + 32'h10;
    #1;
    compared++;
    if (irqHit !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dec_hit_outside: got %b expected 0", irqHit);
    end
    busWrite(32'h14, 32'hFFFF);
    busRead(32'h4, rd);
    compared++;
    if (rd !== 32'h0F) begin
      mismatched++;
      $display("[TB] FAIL dec_no_alias: got %h expected 0000000f", rd);
    end
    compared++;
    if (irqHit !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL dec_hit_inside: got %b expected 1", irqHit);
    end
    busWrite(32'h4, 32'hFFFF);
    busRead(32'h4, rd);
    compared++;
    if (rd !== 32'hFF) begin
      mismatched++;
      $display("[TB] FAIL dec_width: got %h expected 000000ff", rd);
    end
  endtask

  // T1b: asynchronous reset while a source is in service.
  task automatic test_reset_in_service();
    logic [31:0] rd;
    pulseIrq(8'h01);
    tick(2);
    takeIrq();
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h8000_0000) begin
      mismatched++;
      $display("[TB] FAIL rsvc_in_service: got %h expected 80000000", rd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (intr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rsvc_intr: got %b expected 0", intr);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    busRead(32'h4, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rsvc_enable: got %h expected 00000000", rd);
    end
    busRead(32'h8, rd);
    compared++;
    if (rd !== 32'hFF) begin
      mismatched++;
      $display("[TB] FAIL rsvc_mode: got %h expected 000000ff", rd);
    end
    busRead(32'hC, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rsvc_claim: got %h expected 00000000", rd);
    end
    busWrite(32'h4, 32'h01);
    pulseIrq(8'h01);
    tick(2);
    compared++;
    if (intr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rsvc_back_to_idle: got %b expected 1", intr);
    end
  endtask

  initial begin
    irqIn    = 8'h00;
    ioAddr   = 32'h0;
    ioOut    = 32'h0;
    ioWr     = 1'b0;
    intTaken = 1'b0;
    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_collisions();
    test_enable_drop();
    test_decode();
    test_reset_in_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
